// File: rtl/alu_pkg.sv
// alu_pkg: shared types and helpers for the ALU and its request arbiter.
//   op_e     - 4-bit ALU opcode (values 10..15 are illegal)
//   state_e  - arbiter FSM states
//   flags_t  - {neg, zero, cout, ovf}
//   OP_MAX   - highest legal opcode
//   seg7     - hex digit to 7-segment pattern (gfedcba, active-high)
package alu_pkg;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_NOT, OP_AND, OP_OR, OP_XOR, OP_SRL, OP_SLL, OP_SRA, OP_SLA
    } op_e;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    typedef struct packed {
        logic neg;
        logic zero;
        logic cout;
        logic ovf;
    } flags_t;

    localparam logic [3:0] OP_MAX = 4'd9;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: seg7 = 7'h3F;
            4'h1: seg7 = 7'h06;
            4'h2: seg7 = 7'h5B;
            4'h3: seg7 = 7'h4F;
            4'h4: seg7 = 7'h66;
            4'h5: seg7 = 7'h6D;
            4'h6: seg7 = 7'h7D;
            4'h7: seg7 = 7'h07;
            4'h8: seg7 = 7'h7F;
            4'h9: seg7 = 7'h6F;
            4'hA: seg7 = 7'h77;
            4'hB: seg7 = 7'h7C;
            4'hC: seg7 = 7'h39;
            4'hD: seg7 = 7'h5E;
            4'hE: seg7 = 7'h79;
            default: seg7 = 7'h71;
        endcase
    endfunction
endpackage

// File: rtl/alu.sv
// alu: combinational N-bit ALU with active-low operation selector.
//   sel     in  4   active-low opcode (op = ~sel)
//   a, b    in  N   operands (b is the shift amount for shifts)
//   cin     in  1   carry-in for add
//   result  out N   result (0 for illegal opcodes)
//   flags   out 4   {neg, zero, cout, ovf}
//   display out 14  two hex digits of the result as 7-segment patterns
module alu
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [3:0]   sel,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] result,
    output flags_t       flags,
    output logic [13:0]  display
);
    op_e op;
    logic [N:0] sum;
    logic [7:0] r8;

    assign op = op_e'(~sel);

    always_comb begin
        sum    = '0;
        result = '0;
        flags  = '0;
        case (op)
            OP_ADD: begin
                sum        = {1'b0, a} + {1'b0, b} + (N+1)'(cin);
                result     = sum[N-1:0];
                flags.cout = sum[N];
                flags.ovf  = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
            end
            OP_SUB: begin
                // a - b as a + ~b + 1; cout is the no-borrow carry
                sum        = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
                result     = sum[N-1:0];
                flags.cout = sum[N];
                flags.ovf  = (a[N-1] != b[N-1]) && (sum[N-1] != a[N-1]);
            end
            OP_NOT:  result = ~a;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SRL:  result = a >> b;
            OP_SLL:  result = a << b;
            OP_SRA:  result = N'($signed(a) >>> b);
            OP_SLA:  result = a <<< b;
            default: result = '0;
        endcase
        flags.neg  = result[N-1];
        flags.zero = result == '0;
    end

    assign r8      = 8'(result);
    assign display = {seg7(r8[7:4]), seg7(r8[3:0])};
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant; search starts after ptr.
//   req   in  NREQ  request vector
//   ptr   in  IDW   index of the last grant
//   grant out NREQ  one-hot grant (zero when no request)
//   idx   out IDW   granted index
//   any   out 1     at least one request present
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] idx,
    output logic                    any
);
    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0] j;

    // Scan from farthest to nearest so the nearest request after ptr wins.
    always_comb begin
        idx = '0;
        j   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            j = IDW'((int'(ptr) + k) % NREQ);
            if (req[j]) idx = j;
        end
    end

    assign any   = |req;
    assign grant = any ? NREQ'(1) << idx : '0;
endmodule

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one alu between NREQ requesters, one transaction in flight.
//   clk, rst_n            clock, async active-low reset
//   req_valid/req_ready   per-requester request handshake
//   req_op/a/b/cin        per-requester operation fields (slice i per requester)
//   rsp_valid/rsp_ready   shared response handshake
//   rsp_id/result/flags/err  response payload, held stable in RESP
//   busy                  transaction in progress
//   display_0             7-segment pattern of the last legal result
//   done_cnt              8-bit completed-response counter per requester
module alu_req_arbiter
    import alu_pkg::*;
#(
    parameter int N    = 4,
    parameter int NREQ = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [4*NREQ-1:0]       req_op,
    input  logic [N*NREQ-1:0]       req_a,
    input  logic [N*NREQ-1:0]       req_b,
    input  logic [NREQ-1:0]         req_cin,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [N-1:0]            rsp_result,
    output logic [3:0]              rsp_flags,
    output logic                    rsp_err,
    output logic                    busy,
    output logic [13:0]             display_0,
    output logic [8*NREQ-1:0]       done_cnt
);
    localparam int IDW = $clog2(NREQ);
    localparam logic [13:0] DISP_ZERO = {seg7(4'h0), seg7(4'h0)};

    state_e         state, nstate;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0] gidx, rr_ptr, id_q;
    logic           any, illegal;
    logic [3:0]     op_q;
    logic [N-1:0]   a_q, b_q, alu_result;
    logic           cin_q;
    flags_t         alu_flags;
    logic [13:0]    alu_display;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (gidx),
        .any   (any)
    );

    alu #(.N(N)) u_alu (
        .sel     (~op_q),
        .a       (a_q),
        .b       (b_q),
        .cin     (cin_q),
        .result  (alu_result),
        .flags   (alu_flags),
        .display (alu_display)
    );

    assign req_ready = (state == IDLE) ? grant : '0;
    assign rsp_valid = state == RESP;
    assign busy      = state != IDLE;
    assign rsp_id    = id_q;
    assign illegal   = op_q > OP_MAX;

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    nstate = any ? EXEC : IDLE;
            EXEC:    nstate = RESP;
            RESP:    nstate = rsp_ready ? IDLE : RESP;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nstate;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            id_q       <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b0;
            display_0  <= DISP_ZERO;
            done_cnt   <= '0;
        end else begin
            if (state == IDLE && any) begin
                op_q   <= req_op[4*gidx +: 4];
                a_q    <= req_a[N*gidx +: N];
                b_q    <= req_b[N*gidx +: N];
                cin_q  <= req_cin[gidx];
                id_q   <= gidx;
                rr_ptr <= gidx;
            end
            if (state == EXEC) begin
                rsp_result <= illegal ? '0 : alu_result;
                rsp_flags  <= illegal ? '0 : 4'(alu_flags);
                rsp_err    <= illegal;
                if (!illegal) display_0 <= alu_display;
            end
            if (rsp_valid && rsp_ready)
                done_cnt[8*id_q +: 8] <= done_cnt[8*id_q +: 8] + 8'd1;
        end
    end
endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Shares one instance of the existing `alu` datapath between NREQ requesters. Each requester issues an operation over a valid/ready request channel.
- A round-robin arbiter picks one request and captures its operands. The block drives the ALU, registers result and flags, and returns them on a shared response channel tagged with the requester ID.
- Sits between the board-level control logic (switch/button front-ends, test sequencers) and the ALU. It also drives the 7-segment output from the last completed result.

Parameters:
N, 4, operand/result width passed to `alu`
NREQ, 2, number of requesters (legal 2..4)
IDW, $clog2(NREQ), requester ID width (derived, not overridable)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester request accept (one-hot or zero)
req_op  in  4*NREQ  opcode per requester, slice i = [4i+3:4i]
req_a  in  N*NREQ  operand A per requester
req_b  in  N*NREQ  operand B / shift amount per requester
req_cin  in  NREQ  carry-in per requester
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  IDW  requester that owns the response
rsp_result  out  N  ALU result
rsp_flags  out  4  {Neg, Zero, Cout, Overflow}
rsp_err  out  1  opcode illegal (>9)
busy  out  1  state != IDLE
display_0  out  14  7-segment pattern of the last completed result, from `alu`
done_cnt  out  8*NREQ  completed responses per requester, slice i

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset: state=IDLE, rr pointer=0, all outputs 0, display_0 = pattern of result 0, done_cnt=0.
- Reset mid-operation aborts the transaction silently. No response is issued.
- Opcodes (ALU encoding):
  - 0 add, 1 sub, 2 not, 3 and, 4 or, 5 xor
  - 6 srl, 7 sll, 8 sra, 9 sla
  - 10..15 illegal
- ALU selector is active-low. The block drives ~op_q into the `alu` selector.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - The grant is combinational and round-robin. Search starts at the index after the last grant and wraps modulo NREQ.
  - req_ready[g]=1 only for the granted requester, and only when its req_valid=1.
  - On a handshake, capture op/a/b/cin/id into op_q/a_q/b_q/cin_q/id_q, set rr pointer=g, and go to EXEC.
  - With no valid requests, stay in IDLE.
- EXEC (1 cycle):
  - ALU operates combinationally on the captured registers.
  - At the clock edge, register result/flags into rsp_*, set rsp_err, then go to RESP.
  - Illegal op: rsp_result=0, rsp_flags=0, rsp_err=1. The display is not updated.
- RESP:
  - rsp_valid=1; rsp_* held stable until rsp_ready=1.
  - On the handshake: done_cnt[id_q]++ (wraps 255->0), go to IDLE, and drop rsp_valid next cycle.
  - req_ready=0 for all requesters throughout EXEC and RESP.
- Latency: request handshake edge to rsp_valid = 2 cycles. Minimum issue interval = 3 cycles.
- A requester dropping req_valid while not granted is legal. It is not protected: no starvation fairness beyond round-robin.
- The request channel is not buffered: at most one transaction in flight.
- Simultaneous rsp_ready and a new req_valid in RESP: the request is accepted no earlier than the following IDLE cycle.

Decomposition:
- Package alu_pkg:
  - opcode typedef enum (4 bits, ALU encoding above)
  - state enum {IDLE, EXEC, RESP}
  - flags struct {neg, zero, cout, ovf}
  - constant OP_MAX=9
- Sub-module rr_arbiter #(NREQ): inputs req, ptr; outputs onehot grant, grant index, any. Purely combinational; pointer register lives in the top.
- The existing `alu` is instantiated unchanged.

Test Plan:
- Reset then single request: req0 add a=1 b=10 cin=1 -> rsp_valid 2 cycles after handshake; result=12, Cout=0, rsp_id=0, done_cnt[0]=1.
- Both valid continuously:
  - req0 add a=15 b=15 cin=0; req1 and a=9 b=6
  - Required: grants alternate 0,1,0,1; req0 responses result=14 Cout=1; req1 responses result=0 Zero=1.
- Backpressure: rsp_ready=0 for 5 cycles on a sub a=3 b=3 -> result=0 Zero=1 held stable; busy=1; req_ready=0 throughout; accepted on the first cycle rsp_ready=1.
- Illegal op 12 from req1 -> rsp_err=1, result=0, flags=0; display_0 unchanged; done_cnt[1] increments.
- Reset asserted during EXEC of sll a=13 b=1 -> all outputs 0 asynchronously, no response. After release, a new srl a=6 b=1 returns result=3.
- Counter wrap: 256 responses to req0 -> done_cnt[0]=0; done_cnt[1] unaffected.
